// File: rtl/header_parser_pkg.sv
// Shared OpenFlow header-bus layout, ethertype/protocol constants and parser state encoding.
// The matcher and action processor import the same field positions.
package header_parser_pkg;

   localparam int OF_HEADER_REG_WIDTH = 240;

   localparam int OF_TP_DST_POS   = 0;
   localparam int OF_TP_DST_W     = 16;
   localparam int OF_TP_SRC_POS   = 16;
   localparam int OF_TP_SRC_W     = 16;
   localparam int OF_NW_PROTO_POS = 32;
   localparam int OF_NW_PROTO_W   = 8;
   localparam int OF_NW_DST_POS   = 40;
   localparam int OF_NW_DST_W     = 32;
   localparam int OF_NW_SRC_POS   = 72;
   localparam int OF_NW_SRC_W     = 32;
   localparam int OF_DL_TYPE_POS  = 104;
   localparam int OF_DL_TYPE_W    = 16;
   localparam int OF_DL_SRC_POS   = 120;
   localparam int OF_DL_SRC_W     = 48;
   localparam int OF_DL_DST_POS   = 168;
   localparam int OF_DL_DST_W     = 48;
   localparam int OF_DL_VLAN_POS  = 216;
   localparam int OF_DL_VLAN_W    = 16;
   localparam int OF_IN_PORT_POS  = 232;
   localparam int OF_IN_PORT_W    = 8;

   localparam logic [15:0] ETHERTYPE_IP   = 16'h0800;
   localparam logic [15:0] ETHERTYPE_VLAN = 16'h8100;
   localparam logic [15:0] OF_VLAN_NONE   = 16'hFFFF;
   localparam logic [7:0]  IP_PROTO_TCP   = 8'd6;
   localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;

   localparam int CAPTURE_WORDS = 6;
   localparam int CAPTURE_BYTES = 48;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MODHDR,
      ST_CAPTURE,
      ST_EMIT,
      ST_WAIT_EOP
   } parser_state_e;

   function automatic logic is_l4_proto(input logic [7:0] proto);
      return (proto == IP_PROTO_TCP) || (proto == IP_PROTO_UDP);
   endfunction

endpackage

// File: rtl/header_field_extract.sv
// Combinational mapping of the 48-byte capture buffer (byte 0 in the MSBs) plus in_port
// onto the OpenFlow 10-tuple header bus.
module header_field_extract
   import header_parser_pkg::*;
(
   input  logic [CAPTURE_BYTES*8-1:0]     cap_i,
   input  logic [7:0]                     in_port_i,
   output logic [OF_HEADER_REG_WIDTH-1:0] header_bus_o
);

   logic         is_vlan;
   logic [15:0]  dl_type;
   logic [15:0]  dl_vlan;
   logic [239:0] ip_w;
   logic [3:0]   ihl;
   logic [7:0]   nw_proto;
   logic [12:0]  frag_off;
   logic         is_ip;
   logic         has_ports;

   // Byte b of the frame sits at cap_i[383-8b -: 8]; ip_w is a 30-byte window starting at the IP header.
   assign is_vlan   = (cap_i[287:272] == ETHERTYPE_VLAN);
   assign dl_type   = is_vlan ? cap_i[255:240] : cap_i[287:272];
   assign dl_vlan   = is_vlan ? {4'h0, cap_i[267:256]} : OF_VLAN_NONE;
   assign ip_w      = is_vlan ? cap_i[239:0] : cap_i[271:32];
   assign ihl       = ip_w[235:232];
   assign nw_proto  = ip_w[167:160];
   assign frag_off  = ip_w[188:176];
   assign is_ip     = (dl_type == ETHERTYPE_IP);
   assign has_ports = is_ip && (ihl == 4'd5) && is_l4_proto(nw_proto) && (frag_off == 13'd0);

   always_comb begin
      header_bus_o = '0;
      header_bus_o[OF_IN_PORT_POS +: OF_IN_PORT_W] = in_port_i;
      header_bus_o[OF_DL_VLAN_POS +: OF_DL_VLAN_W] = dl_vlan;
      header_bus_o[OF_DL_DST_POS  +: OF_DL_DST_W]  = cap_i[383:336];
      header_bus_o[OF_DL_SRC_POS  +: OF_DL_SRC_W]  = cap_i[335:288];
      header_bus_o[OF_DL_TYPE_POS +: OF_DL_TYPE_W] = dl_type;
      if (is_ip) begin
         header_bus_o[OF_NW_PROTO_POS +: OF_NW_PROTO_W] = nw_proto;
         header_bus_o[OF_NW_SRC_POS   +: OF_NW_SRC_W]   = ip_w[143:112];
         header_bus_o[OF_NW_DST_POS   +: OF_NW_DST_W]   = ip_w[111:80];
      end
      if (has_ports) begin
         header_bus_o[OF_TP_SRC_POS +: OF_TP_SRC_W] = ip_w[79:64];
         header_bus_o[OF_TP_DST_POS +: OF_TP_DST_W] = ip_w[63:48];
      end
   end

   logic unused_ip_bits;
   assign unused_ip_bits = ^{ip_w[239:236], ip_w[231:189], ip_w[175:168], ip_w[159:144], ip_w[47:0]};

endmodule

// File: rtl/header_parser.sv
// Passive tap that captures the IOQ header and first six data words of each packet
// and emits the OpenFlow 10-tuple with a one-cycle headers_valid pulse.
module header_parser
   import header_parser_pkg::*;
#(
   parameter int                    DATA_WIDTH         = 64,
   parameter int                    CTRL_WIDTH         = 8,
   parameter logic [CTRL_WIDTH-1:0] IO_QUEUE_STAGE_NUM = 8'hFF
)(
   input  logic                           clk,
   input  logic                           reset,
   input  logic [DATA_WIDTH-1:0]          in_data,
   input  logic [CTRL_WIDTH-1:0]          in_ctrl,
   input  logic                           in_wr,
   output logic [OF_HEADER_REG_WIDTH-1:0] header_bus,
   output logic                           headers_valid
);

   parser_state_e                  state_q;
   logic [2:0]                     count_q;
   logic                           pending_eop_q;
   logic [7:0]                     in_port_q;
   logic [DATA_WIDTH-1:0]          cap_q [CAPTURE_WORDS];
   logic [OF_HEADER_REG_WIDTH-1:0] header_bus_q;
   logic                           headers_valid_q;

   logic [CAPTURE_WORDS*DATA_WIDTH-1:0] cap_flat;
   logic [OF_HEADER_REG_WIDTH-1:0]      header_bus_d;
   logic                                ioq_hdr;
   logic                                ctrl_word;
   logic                                data_word;

   assign ioq_hdr   = in_wr && (in_ctrl == IO_QUEUE_STAGE_NUM);
   assign ctrl_word = in_wr && (in_ctrl != '0);
   assign data_word = in_wr && (in_ctrl == '0);
   assign cap_flat  = {cap_q[0], cap_q[1], cap_q[2], cap_q[3], cap_q[4], cap_q[5]};

   header_field_extract u_extract (
      .cap_i        (cap_flat),
      .in_port_i    (in_port_q),
      .header_bus_o (header_bus_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         count_q         <= '0;
         pending_eop_q   <= 1'b0;
         in_port_q       <= '0;
         header_bus_q    <= '0;
         headers_valid_q <= 1'b0;
         for (int i = 0; i < CAPTURE_WORDS; i++) cap_q[i] <= '0;
      end else begin
         headers_valid_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (ioq_hdr) begin
                  in_port_q <= in_data[23:16];
                  for (int i = 0; i < CAPTURE_WORDS; i++) cap_q[i] <= '0;
                  state_q <= ST_MODHDR;
               end
            end
            ST_MODHDR: begin
               if (data_word) begin
                  cap_q[0] <= in_data;
                  count_q  <= 3'd1;
                  state_q  <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (in_wr) begin
                  cap_q[count_q] <= in_data;
                  count_q        <= count_q + 3'd1;
                  if ((count_q == 3'd5) || (in_ctrl != '0)) begin
                     state_q       <= ST_EMIT;
                     pending_eop_q <= (in_ctrl == '0);
                  end
               end
            end
            ST_EMIT: begin
               header_bus_q    <= header_bus_d;
               headers_valid_q <= 1'b1;
               // A new IOQ header may already arrive here; take it so back-to-back packets survive.
               if (ioq_hdr) begin
                  in_port_q <= in_data[23:16];
                  for (int i = 0; i < CAPTURE_WORDS; i++) cap_q[i] <= '0;
                  state_q <= ST_MODHDR;
               end else if (ctrl_word) begin
                  state_q <= ST_IDLE;
               end else if (pending_eop_q) begin
                  state_q <= ST_WAIT_EOP;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_WAIT_EOP: begin
               if (ctrl_word) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign header_bus    = header_bus_q;
   assign headers_valid = headers_valid_q;

endmodule

// File: tb/tb_header_parser.sv
// Self-checking bench for header_parser: directed scenarios plus randomized packets
// checked against a byte-level reference model of the OpenFlow tuple extraction.
module tb_header_parser;

   typedef logic [7:0] frame_t [72];

   logic         clk = 1'b0;
   logic         reset;
   logic [63:0]  in_data;
   logic [7:0]   in_ctrl;
   logic         in_wr;
   logic [239:0] header_bus;
   logic         headers_valid;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [239:0] got_hdr_q [$];
   int           got_cyc_q [$];

   always #5 clk = ~clk;

   header_parser dut (
      .clk           (clk),
      .reset         (reset),
      .in_data       (in_data),
      .in_ctrl       (in_ctrl),
      .in_wr         (in_wr),
      .header_bus    (header_bus),
      .headers_valid (headers_valid)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (headers_valid === 1'b1) begin
         got_hdr_q.push_back(header_bus);
         got_cyc_q.push_back(cyc);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Inputs change on the falling edge; "at" is the cycle stamp before the sampling edge.
   task automatic drive(input logic w, input logic [7:0] c, input logic [63:0] d, output int at);
      @(negedge clk);
      in_wr   = w;
      in_ctrl = c;
      in_data = d;
      at      = cyc;
   endtask

   task automatic idle(input int n);
      int t;
      for (int i = 0; i < n; i++) drive(1'b0, 8'hFF, {$urandom(), $urandom()}, t);
   endtask

   function automatic logic [63:0] word_of(input frame_t fr, input int k);
      logic [63:0] w;
      w = '0;
      for (int j = 0; j < 8; j++) w = {w[55:0], fr[8*k+j]};
      return w;
   endfunction

   function automatic logic [239:0] get_h(input int i);
      if (i < got_hdr_q.size()) return got_hdr_q[i];
      return 'x;
   endfunction

   function automatic int get_c(input int i);
      if (i < got_cyc_q.size()) return got_cyc_q[i];
      return -1;
   endfunction

   task automatic got_clear();
      got_hdr_q.delete();
      got_cyc_q.delete();
   endtask

   task automatic make_frame(input logic [47:0] dmac, input logic [47:0] smac, input bit vlan,
                             input logic [15:0] tci, input logic [15:0] etype, input logic [7:0] vihl,
                             input logic [7:0] proto, input logic [15:0] frag, input logic [31:0] sip,
                             input logic [31:0] dip, input logic [15:0] sp, input logic [15:0] dp,
                             output frame_t fr);
      int p;
      for (int i = 0; i < 72; i++) fr[i] = 8'($urandom());
      for (int i = 0; i < 6; i++) begin
         fr[i]   = dmac[47-8*i -: 8];
         fr[6+i] = smac[47-8*i -: 8];
      end
      p = 12;
      if (vlan) begin
         fr[12] = 8'h81; fr[13] = 8'h00; fr[14] = tci[15:8]; fr[15] = tci[7:0];
         p = 16;
      end
      fr[p] = etype[15:8]; fr[p+1] = etype[7:0];
      p = p + 2;
      fr[p]   = vihl;
      fr[p+6] = frag[15:8]; fr[p+7] = frag[7:0];
      fr[p+9] = proto;
      for (int i = 0; i < 4; i++) begin
         fr[p+12+i] = sip[31-8*i -: 8];
         fr[p+16+i] = dip[31-8*i -: 8];
      end
      fr[p+20] = sp[15:8]; fr[p+21] = sp[7:0];
      fr[p+22] = dp[15:8]; fr[p+23] = dp[7:0];
   endtask

   // Reference: only the first min(n,6) words are seen; everything past them reads as zero.
   function automatic logic [239:0] model(input logic [7:0] port, input frame_t fr, input int n);
      logic [7:0]   b [48];
      logic [239:0] h;
      logic [15:0]  typ;
      logic [15:0]  vl;
      logic [7:0]   proto;
      int           o;
      int           avail;
      avail = 8 * ((n < 6) ? n : 6);
      for (int i = 0; i < 48; i++) b[i] = (i < avail) ? fr[i] : 8'h00;
      h = '0;
      h[239:232] = port;
      for (int i = 0; i < 6; i++) begin
         h[215-8*i -: 8] = b[i];
         h[167-8*i -: 8] = b[6+i];
      end
      if ({b[12], b[13]} == 16'h8100) begin
         vl = {4'h0, b[14][3:0], b[15]}; typ = {b[16], b[17]}; o = 18;
      end else begin
         vl = 16'hFFFF; typ = {b[12], b[13]}; o = 14;
      end
      h[231:216] = vl;
      h[119:104] = typ;
      if (typ == 16'h0800) begin
         proto = b[o+9];
         h[39:32]  = proto;
         h[103:72] = {b[o+12], b[o+13], b[o+14], b[o+15]};
         h[71:40]  = {b[o+16], b[o+17], b[o+18], b[o+19]};
         if (b[o][3:0] == 4'd5 && (proto == 8'd6 || proto == 8'd17) && {b[o+6][4:0], b[o+7]} == 13'd0) begin
            h[31:16] = {b[o+20], b[o+21]};
            h[15:0]  = {b[o+22], b[o+23]};
         end
      end
      return h;
   endfunction

   task automatic send_pkt(input logic [7:0] port, input frame_t fr, input int n, input logic [7:0] eop_c,
                           input bit extra_hdr, output int term_at);
      int          t;
      logic [63:0] d;
      d = {$urandom(), $urandom()};
      d[23:16] = port;
      term_at = -100;
      drive(1'b1, 8'hFF, d, t);
      if (extra_hdr) drive(1'b1, 8'h40, {$urandom(), $urandom()}, t);
      for (int k = 0; k < n; k++) begin
         drive(1'b1, (k == n-1) ? eop_c : 8'h00, word_of(fr, k), t);
         if (k == ((n < 6) ? n-1 : 5)) term_at = t;
      end
   endtask

   task automatic test_reset();
      int t;
      reset = 1'b1;
      drive(1'b1, 8'hFF, 64'h0000_0000_0005_0000, t);
      drive(1'b1, 8'h00, {$urandom(), $urandom()}, t);
      idle(2);
      checks++;
      if (headers_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", headers_valid); end
      checks++;
      if (header_bus !== '0) begin errors++; $display("FAIL reset_bus got %h exp 0", header_bus); end
      @(negedge clk);
      reset = 1'b0;
      idle(3);
      checks++;
      if (got_hdr_q.size() != 0) begin errors++; $display("FAIL reset_no_pulse got %0d exp 0", got_hdr_q.size()); end
   endtask

   task automatic test_tcp();
      frame_t fr;
      int term;
      logic [239:0] h, e;
      got_clear();
      make_frame(48'h001122334455, 48'h66778899AABB, 1'b0, 16'h0, 16'h0800, 8'h45, 8'd6, 16'h4000,
                 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, fr);
      send_pkt(8'd2, fr, 8, 8'h80, 1'b1, term);
      idle(4);
      e = model(8'd2, fr, 8);
      h = get_h(0);
      checks++;
      if (got_hdr_q.size() != 1) begin errors++; $display("FAIL tcp_pulses got %0d exp 1", got_hdr_q.size()); end
      checks++;
      if (h !== e) begin errors++; $display("FAIL tcp_hdr got %h exp %h", h, e); end
      checks++;
      if (get_c(0) != term + 2) begin errors++; $display("FAIL tcp_latency got %0d exp %0d", get_c(0), term + 2); end
      checks++;
      if ({h[31:16], h[15:0], h[39:32], h[231:216], h[239:232], h[215:168]} !==
          {16'h04D2, 16'h0050, 8'h06, 16'hFFFF, 8'h02, 48'h001122334455}) begin
         errors++; $display("FAIL tcp_fields got %h", h);
      end
   endtask

   task automatic test_vlan_udp();
      frame_t fr;
      int term;
      logic [239:0] h, e;
      got_clear();
      make_frame({$urandom(), 16'h1234}, {$urandom(), 16'h5678}, 1'b1, 16'h2064, 16'h0800, 8'h45, 8'd17,
                 16'h0000, $urandom(), $urandom(), 16'd53, 16'd5353, fr);
      send_pkt(8'd4, fr, 6, 8'h01, 1'b0, term);
      idle(4);
      e = model(8'd4, fr, 6);
      h = get_h(0);
      checks++;
      if (got_hdr_q.size() != 1) begin errors++; $display("FAIL vlan_pulses got %0d exp 1", got_hdr_q.size()); end
      checks++;
      if (h !== e) begin errors++; $display("FAIL vlan_hdr got %h exp %h", h, e); end
      checks++;
      if (get_c(0) != term + 2) begin errors++; $display("FAIL vlan_latency got %0d exp %0d", get_c(0), term + 2); end
      checks++;
      if ({h[231:216], h[119:104], h[39:32], h[31:16], h[15:0]} !==
          {16'h0064, 16'h0800, 8'h11, 16'h0035, 16'h14E9}) begin
         errors++; $display("FAIL vlan_fields got %h", h);
      end
   endtask

   task automatic test_arp();
      frame_t fr;
      int term;
      logic [239:0] h, e;
      got_clear();
      make_frame(48'hFFFFFFFFFFFF, 48'h0A0B0C0D0E0F, 1'b0, 16'h0, 16'h0806, 8'h45, 8'd6, 16'h0,
                 $urandom(), $urandom(), 16'd1, 16'd2, fr);
      send_pkt(8'd1, fr, 8, 8'h20, 1'b0, term);
      idle(4);
      e = model(8'd1, fr, 8);
      h = get_h(0);
      checks++;
      if (got_hdr_q.size() != 1) begin errors++; $display("FAIL arp_pulses got %0d exp 1", got_hdr_q.size()); end
      checks++;
      if (h !== e) begin errors++; $display("FAIL arp_hdr got %h exp %h", h, e); end
      checks++;
      if ({h[119:104], h[103:0]} !== {16'h0806, 104'h0}) begin errors++; $display("FAIL arp_fields got %h", h); end
   endtask

   task automatic test_runt();
      frame_t fa, fb;
      int ta, tb;
      logic [239:0] h, e;
      got_clear();
      make_frame(48'h020000000001, 48'h020000000002, 1'b0, 16'h0, 16'h0800, 8'h45, 8'd6, 16'h0,
                 32'hC0A80001, 32'hC0A80002, 16'd4000, 16'd22, fa);
      make_frame({$urandom(), 16'h0}, {$urandom(), 16'h1}, 1'b0, 16'h0, 16'h0800, 8'h45, 8'd17, 16'h0,
                 $urandom(), $urandom(), 16'd7, 16'd9, fb);
      send_pkt(8'd5, fa, 3, 8'h80, 1'b0, ta);
      idle(1);
      send_pkt(8'd9, fb, 7, 8'h80, 1'b0, tb);
      idle(4);
      e = model(8'd5, fa, 3);
      h = get_h(0);
      checks++;
      if (got_hdr_q.size() != 2) begin errors++; $display("FAIL runt_pulses got %0d exp 2", got_hdr_q.size()); end
      checks++;
      if (h !== e) begin errors++; $display("FAIL runt_hdr got %h exp %h", h, e); end
      checks++;
      if (get_c(0) != ta + 2) begin errors++; $display("FAIL runt_latency got %0d exp %0d", get_c(0), ta + 2); end
      checks++;
      if ({h[103:40], h[39:32], h[31:0]} !== {64'h0, 8'h06, 32'h0}) begin errors++; $display("FAIL runt_zero got %h", h); end
      e = model(8'd9, fb, 7);
      checks++;
      if (get_h(1) !== e) begin errors++; $display("FAIL runt_next_hdr got %h exp %h", get_h(1), e); end
   endtask

   task automatic test_back_to_back();
      frame_t fa, fb;
      int ta, tb, na;
      logic [239:0] ea, eb;
      for (int v = 0; v < 2; v++) begin
         got_clear();
         na = (v == 0) ? 6 : 4;
         make_frame({$urandom(), 16'hA}, {$urandom(), 16'hB}, 1'b0, 16'h0, 16'h0800, 8'h45, 8'd6, 16'h0,
                    $urandom(), $urandom(), 16'($urandom()), 16'($urandom()), fa);
         make_frame({$urandom(), 16'hC}, {$urandom(), 16'hD}, 1'b1, 16'($urandom()), 16'h0800, 8'h45, 8'd17,
                    16'h0, $urandom(), $urandom(), 16'($urandom()), 16'($urandom()), fb);
         send_pkt(8'd3, fa, na, 8'h80, 1'b0, ta);
         send_pkt(8'd7, fb, 7, 8'h80, 1'b0, tb);
         idle(4);
         ea = model(8'd3, fa, na);
         eb = model(8'd7, fb, 7);
         checks++;
         if (got_hdr_q.size() != 2) begin errors++; $display("FAIL b2b_pulses v%0d got %0d exp 2", v, got_hdr_q.size()); end
         checks++;
         if (get_h(0) !== ea) begin errors++; $display("FAIL b2b_first v%0d got %h exp %h", v, get_h(0), ea); end
         checks++;
         if (get_h(1) !== eb) begin errors++; $display("FAIL b2b_second v%0d got %h exp %h", v, get_h(1), eb); end
         checks++;
         if ({get_h(0)[239:232], get_h(1)[239:232]} !== {8'd3, 8'd7}) begin
            errors++; $display("FAIL b2b_ports v%0d got %h/%h exp 03/07", v, get_h(0)[239:232], get_h(1)[239:232]);
         end
         checks++;
         if (get_c(0) != ta + 2 || get_c(1) != tb + 2) begin
            errors++; $display("FAIL b2b_latency v%0d got %0d/%0d exp %0d/%0d", v, get_c(0), get_c(1), ta + 2, tb + 2);
         end
      end
   endtask

   task automatic test_reset_mid();
      frame_t fr;
      int t, term;
      logic [63:0] d;
      logic [239:0] e;
      got_clear();
      make_frame(48'h0000000000AA, 48'h0000000000BB, 1'b0, 16'h0, 16'h0800, 8'h45, 8'd6, 16'h0,
                 32'h01020304, 32'h05060708, 16'd10, 16'd20, fr);
      d = 64'h0;
      d[23:16] = 8'd5;
      drive(1'b1, 8'hFF, d, t);
      for (int k = 0; k < 3; k++) drive(1'b1, 8'h00, word_of(fr, k), t);
      drive(1'b1, 8'h00, word_of(fr, 3), t);
      reset = 1'b1;
      drive(1'b1, 8'h00, word_of(fr, 4), t);
      reset = 1'b0;
      drive(1'b1, 8'h00, word_of(fr, 5), t);
      drive(1'b1, 8'h80, word_of(fr, 6), t);
      idle(4);
      checks++;
      if (got_hdr_q.size() != 0) begin errors++; $display("FAIL rstmid_no_pulse got %0d exp 0", got_hdr_q.size()); end
      checks++;
      if (header_bus !== '0) begin errors++; $display("FAIL rstmid_bus got %h exp 0", header_bus); end
      send_pkt(8'd6, fr, 6, 8'h80, 1'b0, term);
      idle(4);
      e = model(8'd6, fr, 6);
      checks++;
      if (got_hdr_q.size() != 1) begin errors++; $display("FAIL rstmid_next_pulses got %0d exp 1", got_hdr_q.size()); end
      checks++;
      if (get_h(0) !== e) begin errors++; $display("FAIL rstmid_next_hdr got %h exp %h", get_h(0), e); end
   endtask

   task automatic test_random();
      frame_t fr;
      logic [239:0] exp_h [$];
      int exp_c [$];
      int n, term, sel;
      logic [7:0] port;
      logic [15:0] et, frag;
      logic [7:0] proto, vihl;
      got_clear();
      for (int p = 0; p < 40; p++) begin
         sel = $urandom_range(0, 3);
         et = (sel < 2) ? 16'h0800 : (sel == 2) ? 16'h0806 : 16'($urandom());
         sel = $urandom_range(0, 3);
         proto = (sel == 0) ? 8'd6 : (sel == 1) ? 8'd17 : (sel == 2) ? 8'd1 : 8'($urandom());
         vihl = ($urandom_range(0, 3) == 0) ? 8'h46 : 8'h45;
         sel = $urandom_range(0, 3);
         frag = (sel == 0) ? 16'($urandom()) : (sel == 1) ? 16'h4000 : 16'h0000;
         make_frame({$urandom(), 16'($urandom())}, {$urandom(), 16'($urandom())}, 1'($urandom()),
                    16'($urandom()), et, vihl, proto, frag, $urandom(), $urandom(),
                    16'($urandom()), 16'($urandom()), fr);
         n = $urandom_range(2, 9);
         port = 8'($urandom());
         send_pkt(port, fr, n, 8'($urandom_range(1, 254)), 1'($urandom()), term);
         exp_h.push_back(model(port, fr, n));
         exp_c.push_back(term + 2);
         idle($urandom_range(0, 2));
      end
      idle(4);
      checks++;
      if (got_hdr_q.size() != exp_h.size()) begin
         errors++; $display("FAIL rand_pulses got %0d exp %0d", got_hdr_q.size(), exp_h.size());
      end
      for (int i = 0; i < exp_h.size(); i++) begin
         checks++;
         if (get_h(i) !== exp_h[i]) begin errors++; $display("FAIL rand_hdr[%0d] got %h exp %h", i, get_h(i), exp_h[i]); end
         checks++;
         if (get_c(i) != exp_c[i]) begin errors++; $display("FAIL rand_latency[%0d] got %0d exp %0d", i, get_c(i), exp_c[i]); end
      end
   endtask

   initial begin
      reset   = 1'b1;
      in_wr   = 1'b0;
      in_ctrl = 8'h00;
      in_data = 64'h0;
      test_reset();
      test_tcp();
      test_vlan_udp();
      test_arp();
      test_runt();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
